// File: rtl/tiny_dnn_pkg.sv
// Shared types for the tiny_dnn streaming blocks: sample word, source queue depth,
// and the source feeder state encoding.
package tiny_dnn_pkg;
  localparam int SAMPLE_W   = 32;
  localparam int SRCQ_DEPTH = 2;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    FEED_IDLE  = 2'd0,
    FEED_RUN   = 2'd1,
    FEED_DRAIN = 2'd2
  } feed_state_t;
endpackage

// File: rtl/loop1.sv
// Wrapping index counter: counts 0..max, clears on clr. at_max is combinational from the
// current count, so a caller can detect the wrapping increment in the same cycle.
module loop1 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic         at_max
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    at_max = (cnt_q == max);
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/src_queue.sv
// Two-entry synchronous FIFO; push lands next cycle, head is a registered entry.
// Caller must not push when full; simultaneous push and pop keeps the count.
module src_queue
  import tiny_dnn_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam logic [1:0] DEPTH = 2'(SRCQ_DEPTH);

  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) begin
      if (wr_q) ent1_d = push_dat;
      else      ent0_d = push_dat;
      wr_d = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    full     = (cnt_q == DEPTH);
    empty    = (cnt_q == 2'd0);
    head_dat = rd_q ? ent1_q : ent0_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/src_feeder.sv
// Reads (nb+1) batches of (ss+1) words from a 1-cycle-latency buffer and streams them with
// src_last per batch; first word is visible 2 cycles after start, reads stop once 2 words are owed.
module src_feeder
  import tiny_dnn_pkg::*;
#(
  parameter int DW = SAMPLE_W,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [11:0]   ss,
  input  logic [11:0]   nb,
  output logic          mem_re,
  output logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_d,
  output logic          src_valid,
  output logic [DW-1:0] src_data,
  output logic          src_last,
  input  logic          src_ready,
  output logic          busy,
  output logic          done
);
  feed_state_t   state_q, state_d;
  logic [11:0]   ss_q, ss_d, nb_q, nb_d;
  logic [AW-1:0] ra_q, ra_d;
  logic          inflight_q, inflight_d;
  logic          infl_last_q, infl_last_d;
  logic          done_q, done_d;

  logic          start_acc, issue, pop, q_push, q_pop, q_full, q_empty;
  logic          wi_at_max, bi_at_max;
  logic [1:0]    occ;
  logic [2:0]    credit;
  logic [DW:0]   q_head;

  src_queue #(.W(DW + 1)) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_dat ({infl_last_q, mem_d}),
    .pop      (q_pop),
    .full     (q_full),
    .empty    (q_empty),
    .head_dat (q_head)
  );

  loop1 #(.W(12)) u_wi (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_acc),
    .inc    (issue),
    .max    (ss_q),
    .at_max (wi_at_max)
  );

  loop1 #(.W(12)) u_bi (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_acc),
    .inc    (issue & wi_at_max),
    .max    (nb_q),
    .at_max (bi_at_max)
  );

  // The returning read counts as queued: it is shown directly when the queue is empty,
  // and is only written into the queue if it is not taken this cycle.
  always_comb begin
    occ       = q_full ? 2'd2 : (q_empty ? 2'd0 : 2'd1);
    src_valid = ~q_empty | inflight_q;
    pop       = src_valid & src_ready;
    credit    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    start_acc = (state_q == FEED_IDLE) & start;
    issue     = (state_q == FEED_RUN) & (credit < 3'd2);
    q_pop     = pop & ~q_empty;
    q_push    = inflight_q & ~(q_empty & pop);
    mem_re    = issue;
    mem_a     = issue ? ra_q : '0;
    if (q_empty) {src_last, src_data} = inflight_q ? {infl_last_q, mem_d} : '0;
    else         {src_last, src_data} = q_head;
    busy      = (state_q != FEED_IDLE);
    done      = done_q;
  end

  always_comb begin
    state_d     = state_q;
    ss_d        = ss_q;
    nb_d        = nb_q;
    ra_d        = ra_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    infl_last_d = issue & wi_at_max;
    case (state_q)
      FEED_IDLE: begin
        if (start) begin
          ss_d    = ss;
          nb_d    = nb;
          ra_d    = base;
          state_d = FEED_RUN;
        end
      end
      FEED_RUN: begin
        if (issue) begin
          ra_d = ra_q + AW'(1);
          if (wi_at_max & bi_at_max) state_d = FEED_DRAIN;
        end
      end
      FEED_DRAIN: begin
        if (credit == 3'd0) begin
          done_d  = 1'b1;
          state_d = FEED_IDLE;
        end
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FEED_IDLE;
      ss_q        <= '0;
      nb_q        <= '0;
      ra_q        <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      nb_q        <= nb_d;
      ra_q        <= ra_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: doc/src_feeder.md
# src_feeder

Stream transmitter that drives the batch controller's source port (`src_valid`/`src_ready`/`src_last`/data) from a word-addressed sample buffer. On `start` it reads `nb+1` batches of `ss+1` words each from consecutive buffer addresses beginning at `base`, and marks the final word of every batch with `src_last`. The buffer has one-cycle read latency, so the block keeps a two-entry output queue and never loses a word under backpressure. It sits between the host-loaded sample RAM and the batch controller input.

## Interface
- `DW`, 32, data word width
- `AW`, 16, buffer address width
- `clk` input 1, single clock, all state on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `start` input 1, one-cycle pulse; begins a transfer when idle, ignored otherwise
- `base` input AW, first buffer address; sampled on accepted `start`
- `ss` input 12, last word index in a batch (batch length `ss+1`); sampled on `start`
- `nb` input 12, last batch index (batch count `nb+1`); sampled on `start`
- `mem_re` output 1, buffer read enable
- `mem_a` output AW, buffer read address
- `mem_d` input DW, read data, valid the cycle after `mem_re`
- `src_valid` output 1, head of queue holds a word
- `src_data` output DW, head word
- `src_last` output 1, head word is word `ss` of its batch
- `src_ready` input 1, sink accepts when high with `src_valid`
- `busy` output 1, transfer in progress
- `done` output 1, one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start` latches `base`, `ss`, `nb`; clears word counter `wi`, batch counter `bi`, address counter `ra`; enters RUN.
- RUN: issue a read (`mem_re`=1, `mem_a`=`ra`) when queue occupancy plus in-flight reads is below 2. Each issue: `ra` += 1 (wraps mod 2^AW); `wi` += 1, or, when `wi`==`ss`, `wi` returns to 0 and `bi` += 1. The last flag is `wi`==`ss` at issue time and travels with the read.
- The issue for `wi`==`ss` and `bi`==`nb` is the final read: enter DRAIN in the same cycle.
- DRAIN: no reads; wait until the queue is empty and nothing is in flight, then pulse `done` and return to IDLE.
- Queue: two entries of {data, last}. The read returning from the previous cycle writes `mem_d` and its flag. Pop when `src_valid & src_ready`. A simultaneous push and pop keeps occupancy unchanged. Order is strictly FIFO.
- `src_valid` = queue non-empty. `src_data`/`src_last` show the head entry and stay stable while `src_valid & ~src_ready`.
- `busy` = state != IDLE.
- `start` while busy has no effect.
- `ss`=0: every word carries `src_last`. `nb`=0: exactly one batch.
- Total words issued = (nb+1)*(ss+1). `ra` wraps silently.
- Reset (asynchronous, any time, including mid-transfer): state IDLE, queue empty, in-flight cleared, counters 0. Outputs `mem_re`, `src_valid`, `src_last`, `busy`, `done` = 0; `mem_a`, `src_data` = 0.

## Timing
- `start` at cycle 0 → first `mem_re` at cycle 1 → `src_valid` at cycle 2.
- With `src_ready` held high, the block sustains one word per cycle. Last word is accepted at cycle N+1 for N total words; `done` is high at cycle N+2.
- `mem_re` is combinational from state, occupancy and `src_ready`. It may issue in the same cycle a pop frees a slot: credit = occupancy + inflight − pop < 2.
- Backpressure: `src_ready` low stalls reads within 2 words; there is no overflow and no bubble on release.

## Structure
- Shared package `tiny_dnn_pkg`: typedef `sample_t` (DW bits), queue depth constant `SRCQ_DEPTH`=2, state enum `feed_state_t`.
- Sub-module `src_queue`: 2-entry synchronous FIFO with push, pop, full, empty, and head outputs. Counters are inline, using the codebase `loop1` counter for `wi`/`bi`.

## Test plan
- `base`=0x0100, `ss`=3, `nb`=1, `src_ready`=1 → 8 words from 0x0100–0x0107 on 8 consecutive cycles; `src_last` on words 3 and 7; `done` two cycles after `start`+8.
- Same config, `src_ready` toggled 1/0 each cycle → same 8 words in order, none duplicated, `mem_re` never lets occupancy exceed 2.
- `ss`=0, `nb`=2 → 3 words, all with `src_last`=1.
- `base`=0xFFFE, `ss`=3, `nb`=0 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `src_ready` low for 20 cycles after `start` → `src_valid` high, head stable, exactly 2 reads issued; on release, all words stream without a gap.
- Assert `rst_n` low mid-batch, then `start` again → all outputs 0 during reset; the new transfer begins from the new `base` with `wi`=0.
